// File: rtl/rv32_seq_injector_pkg.sv
// Shared definitions for the self-test sequence injector and the writeback monitor.
// Holds the FSM state type and the default instruction words of the sequence.
package rv32_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // Single source of truth for the four self-test instruction words.
    localparam logic [31:0] STEP0_DEFAULT = 32'h0ff7_f713;
    localparam logic [31:0] STEP1_DEFAULT = 32'h0087_f793;
    localparam logic [31:0] STEP2_DEFAULT = 32'h0007_8e63;
    localparam logic [31:0] STEP3_DEFAULT = 32'h0017_7793;

    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/rv32_seq_injector_if.sv
// Control and instruction-stream bundle between the hazard/trigger side and the injector.
// valid_out qualifies instr_out/pc_out; there is no ready, stall_in freezes the stage instead.
interface rv32_seq_injector_if;
    import rv32_seq_pkg::*;

    logic        start_in;
    logic [31:0] pc_base_in;
    logic        stall_in;
    logic        flush_in;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        busy_out;
    logic        done_out;
    logic        abort_out;
    logic [1:0]  index_out;
    seq_state_e  state_out;

    modport master (
        output start_in, pc_base_in, stall_in, flush_in,
        input  valid_out, instr_out, pc_out, busy_out, done_out, abort_out,
        input  index_out, state_out
    );

    modport slave (
        input  start_in, pc_base_in, stall_in, flush_in,
        output valid_out, instr_out, pc_out, busy_out, done_out, abort_out,
        output index_out, state_out
    );

endinterface

// File: rtl/rv32_seq_injector_gap_timer.sv
// Loadable 4-bit down-counter that times the bubble cycles between emitted instructions.
// Load wins over enable; the count saturates at zero.
module rv32_seq_gap_timer
    import rv32_seq_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [GAP_CNT_W-1:0] load_val_i,
    input  logic                 en_i,
    output logic                 zero_o
);

    logic [GAP_CNT_W-1:0] cnt_q;
    logic [GAP_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - GAP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rv32_seq_injector.sv
// Self-test source: on one trigger emits STEP0..STEP3 as a valid-qualified stream with PCs,
// behaving like a pipeline stage under hazard stall (freeze) and flush (abort).
module rv32_seq_injector
    import rv32_seq_pkg::*;
#(
    parameter logic [31:0] STEP0     = STEP0_DEFAULT,
    parameter logic [31:0] STEP1     = STEP1_DEFAULT,
    parameter logic [31:0] STEP2     = STEP2_DEFAULT,
    parameter logic [31:0] STEP3     = STEP3_DEFAULT,
    parameter int          GAP       = 0,
    parameter int          PC_STRIDE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rv32_seq_injector_if.slave   bus
);

    seq_state_e  state_q;
    logic [1:0]  index_q;
    logic [31:0] base_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        done_q;
    logic        abort_q;

    logic [31:0] pc_calc;
    logic        timer_load;
    logic        timer_en;
    logic        gap_zero;

    function automatic logic [31:0] step_word(input logic [1:0] idx);
        case (idx)
            2'd0:    return STEP0;
            2'd1:    return STEP1;
            2'd2:    return STEP2;
            default: return STEP3;
        endcase
    endfunction

    assign pc_calc = base_q + (32'(index_q) * 32'(PC_STRIDE));

    // The timer only moves on unstalled, unflushed cycles so it freezes with the FSM.
    assign timer_load = !bus.stall_in && !bus.flush_in && (state_q == ST_EMIT) && (index_q != 2'd3);
    assign timer_en   = !bus.stall_in && !bus.flush_in && (state_q == ST_GAP);

    if (GAP > 0) begin : g_timer
        rv32_seq_gap_timer u_gap_timer (
            .clk_i      (clk),
            .rst_ni     (reset),
            .load_i     (timer_load),
            .load_val_i (GAP_CNT_W'(GAP - 1)),
            .en_i       (timer_en),
            .zero_o     (gap_zero)
        );
    end else begin : g_no_timer
        logic unused_timer;
        assign unused_timer = timer_load ^ timer_en;
        assign gap_zero     = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            index_q <= 2'd0;
            base_q  <= 32'd0;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else if (!bus.stall_in) begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start_in) begin
                        base_q  <= bus.pc_base_in;
                        index_q <= 2'd0;
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (bus.flush_in) begin
                        valid_q <= 1'b0;
                        abort_q <= 1'b1;
                        index_q <= 2'd0;
                        state_q <= ST_IDLE;
                    end else begin
                        valid_q <= 1'b1;
                        instr_q <= step_word(index_q);
                        pc_q    <= pc_calc;
                        if (index_q == 2'd3) begin
                            state_q <= ST_DONE;
                        end else if (GAP > 0) begin
                            state_q <= ST_GAP;
                        end else begin
                            index_q <= index_q + 2'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (bus.flush_in) begin
                        valid_q <= 1'b0;
                        abort_q <= 1'b1;
                        index_q <= 2'd0;
                        state_q <= ST_IDLE;
                    end else begin
                        valid_q <= 1'b0;
                        if (gap_zero) begin
                            index_q <= index_q + 2'd1;
                            state_q <= ST_EMIT;
                        end
                    end
                end
                ST_DONE: begin
                    // DONE spans the pulse cycle so a start coinciding with done_out is refused.
                    valid_q <= 1'b0;
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.instr_out = instr_q;
    assign bus.pc_out    = pc_q;
    assign bus.busy_out  = (state_q == ST_EMIT) || (state_q == ST_GAP);
    assign bus.done_out  = done_q && !bus.stall_in;
    assign bus.abort_out = abort_q && !bus.stall_in;
    assign bus.index_out = index_q;
    assign bus.state_out = state_q;

endmodule
